feedback_frame_decoder: RTL and testbench

Parametrised successor to the single-byte feedback receiver. It assembles NUM_SIG feedback signals from one or more UART bytes, each carrying a 2-bit type code and a 6-bit payload. It sits between the UART RX byte strobe (already synchronised into clk) and the status LEDs / control logic. Over the single-byte receiver it adds:
- multi-byte frames
- an inter-byte timeout
- an error flag
- update and change pulses

---
 rtl/feedback_frame_decoder.sv | 168 ++++++++++++++++
 tb/tb_feedback_frame_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/feedback_frame_decoder.sv
// Multi-byte feedback frame decoder. It assembles NUM_SIG feedback bits from
// UART bytes. Each byte carries a 2-bit type code and a 6-bit payload. The
// decoder times out between bytes and pulses update, change and error flags.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a FEEDBACK_CODE byte that starts a frame
// COLLECT | frame started; waiting for CONT_CODE bytes 1..NBYTES-1
module feedback_frame_decoder #(
    parameter int         NUM_SIG        = 4,
    parameter logic [1:0] FEEDBACK_CODE  = 2'b01,
    parameter logic [1:0] CONT_CODE      = 2'b11,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               script_mode,
    input  logic               data_valid,
    input  logic [7:0]         data_receive,
    output logic [NUM_SIG-1:0] sig,
    output logic [NUM_SIG-1:0] feedback_leds,
    output logic               led_mode,
    output logic               sig_update,
    output logic               sig_changed,
    output logic               frame_error,
    output logic               busy
);

    localparam int NBYTES = (NUM_SIG + 5) / 6;
    localparam int AW     = 6 * NBYTES;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Timer value that, after one more idle cycle, reaches TIMEOUT_CYCLES.
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [TW-1:0]      timer, timer_n;
    logic [AW-1:0]      asm_q, asm_n;
    logic [NUM_SIG-1:0] sig_n;
    logic               led_mode_n, upd_n, chg_n, err_n;
    logic               do_commit, do_clear;
    logic [1:0]         code;
    logic [5:0]         payload;

    assign code          = data_receive[1:0];
    assign payload       = data_receive[7:2];
    assign feedback_leds = sig;
    assign busy          = (state == COLLECT);

    // State and output registers; every pulse is one cycle because it is
    // recomputed with a zero default on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            asm_q       <= '0;
            sig         <= '0;
            led_mode    <= 1'b0;
            sig_update  <= 1'b0;
            sig_changed <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            timer       <= timer_n;
            asm_q       <= asm_n;
            sig         <= sig_n;
            led_mode    <= led_mode_n;
            sig_update  <= upd_n;
            sig_changed <= chg_n;
            frame_error <= err_n;
        end
    end

    // Next-state decode, byte placement, timeout, and commit/clear actions.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        timer_n    = timer;
        asm_n      = asm_q;
        sig_n      = sig;
        led_mode_n = led_mode;
        upd_n      = 1'b0;
        chg_n      = 1'b0;
        err_n      = 1'b0;
        do_commit  = 1'b0;
        do_clear   = 1'b0;

        if (script_mode) begin
            // Script mode aborts any frame silently.
            state_n = IDLE;
            timer_n = '0;
            if (data_valid) do_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        if (code == FEEDBACK_CODE) begin
                            asm_n[5:0] = payload;
                            if (NBYTES == 1) begin
                                do_commit = 1'b1;
                            end else begin
                                state_n = COLLECT;
                                idx_n   = IW'(1);
                                timer_n = '0;
                            end
                        end else if (code == CONT_CODE) begin
                            err_n = 1'b1;
                        end else begin
                            do_clear = 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (data_valid) begin
                        if (code == CONT_CODE) begin
                            for (int k = 0; k < NBYTES; k++) begin
                                if (idx == IW'(k)) asm_n[k*6 +: 6] = payload;
                            end
                            if (idx == IW'(NBYTES - 1)) begin
                                do_commit = 1'b1;
                            end else begin
                                idx_n   = idx + 1'b1;
                                timer_n = '0;
                            end
                        end else if (code == FEEDBACK_CODE) begin
                            err_n      = 1'b1;
                            asm_n[5:0] = payload;
                            idx_n      = IW'(1);
                            timer_n    = '0;
                        end else begin
                            err_n    = 1'b1;
                            do_clear = 1'b1;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (timer == T_LAST)) begin
                        // Partial frame is discarded; committed outputs stay.
                        err_n   = 1'b1;
                        state_n = IDLE;
                        timer_n = '0;
                    end else if (timer != '1) begin
                        timer_n = timer + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (do_commit) begin
            sig_n      = asm_n[NUM_SIG-1:0];
            led_mode_n = 1'b1;
            upd_n      = 1'b1;
            chg_n      = (asm_n[NUM_SIG-1:0] != sig);
            state_n    = IDLE;
            timer_n    = '0;
        end else if (do_clear) begin
            sig_n      = '0;
            led_mode_n = 1'b0;
            chg_n      = (sig != '0);
            state_n    = IDLE;
            timer_n    = '0;
        end
    end

endmodule

// File: tb/tb_feedback_frame_decoder.sv
// Directed bench for feedback_frame_decoder. It drives a single-byte
// instance (NUM_SIG=4) and a two-byte instance (NUM_SIG=10, short timeout).
module tb_feedback_frame_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       sm4 = 1'b0, dv4 = 1'b0;
    logic [7:0] d4 = '0;
    logic [3:0] sig4, leds4;
    logic       lm4, upd4, chg4, err4, busy4;

    logic       sm10 = 1'b0, dv10 = 1'b0;
    logic [7:0] d10 = '0;
    logic [9:0] sig10, leds10;
    logic       lm10, upd10, chg10, err10, busy10;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    feedback_frame_decoder #(.NUM_SIG(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .script_mode(sm4), .data_valid(dv4),
        .data_receive(d4), .sig(sig4), .feedback_leds(leds4), .led_mode(lm4),
        .sig_update(upd4), .sig_changed(chg4), .frame_error(err4), .busy(busy4)
    );

    feedback_frame_decoder #(.NUM_SIG(10), .TIMEOUT_CYCLES(8)) dut10 (
        .clk(clk), .rst_n(rst_n), .script_mode(sm10), .data_valid(dv10),
        .data_receive(d10), .sig(sig10), .feedback_leds(leds10), .led_mode(lm10),
        .sig_update(upd10), .sig_changed(chg10), .frame_error(err10), .busy(busy10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns at the negedge after the edge
    // that consumed it, where the registered results are visible.
    task automatic send4(input logic [7:0] b);
        @(negedge clk);
        d4 = b; dv4 = 1'b1;
        @(negedge clk);
        dv4 = 1'b0;
    endtask

    task automatic send10(input logic [7:0] b);
        @(negedge clk);
        d10 = b; dv10 = 1'b1;
        @(negedge clk);
        dv10 = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst sig4", 32'(sig4), 0);
        chk("rst leds4", 32'(leds4), 0);
        chk("rst flags4", {lm4, upd4, chg4, err4, busy4}, 0);
        chk("rst sig10", 32'(sig10), 0);
        chk("rst flags10", {lm10, upd10, chg10, err10, busy10}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-byte frame, commit, then identical frame.
        send4(8'h15);
        chk("c1 sig", 32'(sig4), 4'b0101);
        chk("c1 leds", 32'(leds4), 4'b0101);
        chk("c1 led_mode", 32'(lm4), 1);
        chk("c1 upd", 32'(upd4), 1);
        chk("c1 chg", 32'(chg4), 1);
        chk("c1 err", 32'(err4), 0);
        @(negedge clk);
        chk("c1 upd pulse ends", 32'(upd4), 0);
        chk("c1 chg pulse ends", 32'(chg4), 0);
        send4(8'h15);
        chk("c2 upd", 32'(upd4), 1);
        chk("c2 chg", 32'(chg4), 0);

        // Continuation byte in IDLE is dropped with an error.
        send4(8'h07);
        chk("idle cont err", 32'(err4), 1);
        chk("idle cont sig", 32'(sig4), 4'b0101);
        chk("idle cont upd", 32'(upd4), 0);

        // Other code clears.
        send4(8'h02);
        chk("clr sig", 32'(sig4), 0);
        chk("clr led_mode", 32'(lm4), 0);
        chk("clr chg", 32'(chg4), 1);
        chk("clr err", 32'(err4), 0);
        chk("clr upd", 32'(upd4), 0);

        // Script mode clear, no error.
        send4(8'h15);
        chk("pre script sig", 32'(sig4), 4'b0101);
        sm4 = 1'b1;
        send4(8'h02);
        chk("script sig", 32'(sig4), 0);
        chk("script chg", 32'(chg4), 1);
        chk("script err", 32'(err4), 0);
        chk("script led_mode", 32'(lm4), 0);
        sm4 = 1'b0;

        // Two-byte frame.
        send10(8'hA9);
        chk("f1 busy", 32'(busy10), 1);
        chk("f1 sig held", 32'(sig10), 0);
        chk("f1 upd", 32'(upd10), 0);
        send10(8'h1B);
        chk("f2 sig", 32'(sig10), 10'h1AA);
        chk("f2 leds", 32'(leds10), 10'h1AA);
        chk("f2 led_mode", 32'(lm10), 1);
        chk("f2 upd", 32'(upd10), 1);
        chk("f2 chg", 32'(chg10), 1);
        chk("f2 busy", 32'(busy10), 0);

        // Inter-byte timeout fires on the 8th idle edge.
        send10(8'hA9);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("to wait%0d err", i), 32'(err10), 0);
            chk($sformatf("to wait%0d busy", i), 32'(busy10), 1);
        end
        @(negedge clk);
        chk("to err", 32'(err10), 1);
        chk("to busy", 32'(busy10), 0);
        chk("to sig", 32'(sig10), 10'h1AA);
        send10(8'h1B);
        chk("late cont err", 32'(err10), 1);
        chk("late cont sig", 32'(sig10), 10'h1AA);
        chk("late cont upd", 32'(upd10), 0);

        // Restart with a new FEEDBACK byte mid-frame.
        send10(8'hA9);
        send10(8'h05);
        chk("restart err", 32'(err10), 1);
        chk("restart busy", 32'(busy10), 1);
        chk("restart sig held", 32'(sig10), 10'h1AA);
        send10(8'h1B);
        chk("restart sig", 32'(sig10), 10'h181);
        chk("restart upd", 32'(upd10), 1);
        chk("restart err end", 32'(err10), 0);

        // Asynchronous reset mid-frame.
        send10(8'hA9);
        chk("pre rst busy", 32'(busy10), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst sig", 32'(sig10), 0);
        chk("arst leds", 32'(leds10), 0);
        chk("arst flags", {lm10, upd10, chg10, err10, busy10}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send10(8'h1B);
        chk("post rst err", 32'(err10), 1);
        chk("post rst sig", 32'(sig10), 0);
        chk("post rst busy", 32'(busy10), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
